psram_rx: RTL and testbench

PSRAM_RX -- requirements
Module: psram_rx

---
 rtl/psram_rx_if.sv | 29 ++
 rtl/psram_rx.sv | 170 +++++++++++++++++
 tb/tb_psram_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_rx_if.sv
// PSRAM receive-path bundle: burst control, raw PSRAM pins, status and
// the word-stream read port. slave = the receiver, master = its driver.
interface psram_rx_if #(
  parameter int TMO_WIDTH = 8
);
  logic                 start_i;
  logic [7:0]           len_i;
  logic [TMO_WIDTH-1:0] tmo_i;
  logic                 psram_dqs_in_i;
  logic [7:0]           psram_io_in_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 tmo_err_o;
  logic                 ovf_err_o;
  logic [31:0]          rdata_o;
  logic                 rvalid_o;
  logic                 rlast_o;
  logic                 rready_i;

  modport slave (
    input  start_i, len_i, tmo_i, psram_dqs_in_i, psram_io_in_i, rready_i,
    output busy_o, done_o, tmo_err_o, ovf_err_o, rdata_o, rvalid_o, rlast_o
  );

  modport master (
    output start_i, len_i, tmo_i, psram_dqs_in_i, psram_io_in_i, rready_i,
    input  busy_o, done_o, tmo_err_o, ovf_err_o, rdata_o, rvalid_o, rlast_o
  );
endinterface

// File: rtl/psram_rx.sv
// PSRAM DDR read receiver: synchronises DQS/DQ, captures one byte per DQS
// edge, packs little-endian 32-bit words and queues them in a small FIFO.
module psram_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_WIDTH  = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  psram_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NUM_LANES = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  // Synchroniser: dqs_pipe[0]/[1] are the two capture stages, [2] is the
  // history tap used for edge detection.
  logic [2:0] dqs_pipe;
  logic [7:0] dq_s1, dq_s2;

  logic [1:0]                          state;
  logic [7:0]                          len_r;
  logic [TMO_WIDTH-1:0]                tmo_r;
  logic [7:0]                          byte_cnt;
  logic [TMO_WIDTH-1:0]                tmo_cnt;
  logic [NUM_LANES-1:0][7:0]           asm_q;
  logic [NUM_LANES-1:0][7:0]           asm_nxt;
  logic                                push_pend;
  logic [31:0]                         push_word;
  logic                                push_last;
  logic                                tmo_err;
  logic                                ovf_err;

  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [32:0] head;

  logic                 dqs_edge, busy, start_acc, cap, last_byte, word_done;
  logic                 fin, tmo_hit;
  logic [1:0]           lane;
  logic [TMO_WIDTH-1:0] tmo_cnt_inc;
  logic                 empty, full, pop, push_ok, drop;

  assign dqs_edge    = dqs_pipe[1] ^ dqs_pipe[2];
  assign busy        = (state == S_WAIT) || (state == S_CAPT);
  assign start_acc   = bus.start_i && (state == S_IDLE) && (bus.len_i != 8'd0);
  // Edges arriving after the last byte of the burst are not captured.
  assign cap         = dqs_edge && busy && (byte_cnt != len_r);
  assign lane        = byte_cnt[1:0];
  assign last_byte   = ((byte_cnt + 8'd1) == len_r);
  assign word_done   = cap && ((lane == 2'd3) || last_byte);
  // Final word sits in push_pend for one cycle; that cycle is the done cycle.
  assign fin         = push_pend && push_last;
  assign tmo_cnt_inc = tmo_cnt + TMO_WIDTH'(1);
  assign tmo_hit     = busy && !dqs_edge && !fin && (tmo_r != '0) &&
                       (tmo_cnt_inc == tmo_r);

  // Byte lane steering: only the lane selected by byte_cnt takes the new byte.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign asm_nxt[l] = (cap && (lane == 2'(l))) ? dq_s2 : asm_q[l];
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.rready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_pend && (!full || pop);
  assign drop    = push_pend && full && !pop;
  assign head    = mem[rd_ptr[AW-1:0]];

  assign bus.busy_o    = busy;
  assign bus.done_o    = fin;
  assign bus.tmo_err_o = tmo_err;
  assign bus.ovf_err_o = ovf_err;
  assign bus.rvalid_o  = !empty;
  assign bus.rdata_o   = empty ? 32'd0 : head[31:0];
  assign bus.rlast_o   = !empty && head[32];

  // Two-stage synchroniser for DQS and DQ plus DQS history tap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dqs_pipe <= '0;
      dq_s1    <= '0;
      dq_s2    <= '0;
    end else begin
      dqs_pipe <= {dqs_pipe[1:0], bus.psram_dqs_in_i};
      dq_s1    <= bus.psram_io_in_i;
      dq_s2    <= dq_s1;
    end
  end

  // Burst FSM: arming, byte capture/word assembly, timeout and error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      len_r     <= '0;
      tmo_r     <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      asm_q     <= '0;
      push_pend <= 1'b0;
      push_word <= '0;
      push_last <= 1'b0;
      tmo_err   <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            state    <= S_WAIT;
            len_r    <= bus.len_i;
            tmo_r    <= bus.tmo_i;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            asm_q    <= '0;
            tmo_err  <= 1'b0;
            ovf_err  <= 1'b0;
          end
        end
        S_WAIT, S_CAPT: begin
          if (fin) begin
            state <= S_IDLE;
          end else if (tmo_hit) begin
            // Partial word is thrown away; a full word already queued in
            // push_pend still goes out this cycle.
            state   <= S_IDLE;
            tmo_err <= 1'b1;
            asm_q   <= '0;
          end else begin
            tmo_cnt <= dqs_edge ? '0 : tmo_cnt_inc;
            if (cap) begin
              state    <= S_CAPT;
              byte_cnt <= byte_cnt + 8'd1;
              if (word_done) begin
                push_pend <= 1'b1;
                push_word <= asm_nxt;
                push_last <= last_byte;
                asm_q     <= '0;
              end else begin
                asm_q <= asm_nxt;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (drop) ovf_err <= 1'b1;
    end
  end

  // FIFO pointers; pop is independent of the burst FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage: {rlast, word}. Contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {push_last, push_word};
  end
endmodule

// File: tb/tb_psram_rx.sv
// Randomised scoreboard bench for psram_rx: the stimulus side predicts the
// word stream from the byte list, a monitor pops and compares.
module tb_psram_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_rx_if #(.TMO_WIDTH(8)) bus ();

  psram_rx #(.FIFO_DEPTH(4), .TMO_WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int rr_mode = 0;  // 0: rready low, 1: random (>=1 in 3 high), 2: high
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bytes packed little-endian into words, last word flagged.
  task automatic model_words(input logic [7:0] b[$], input int keep);
    int nw;
    logic [31:0] w;
    nw = (b.size() + 3) / 4;
    for (int i = 0; i < nw && i < keep; i++) begin
      w = 32'd0;
      for (int l = 0; l < 4; l++)
        if (i * 4 + l < b.size()) w[l*8 +: 8] = b[i*4 + l];
      exp_q.push_back({(i == nw - 1), w});
    end
  endtask

  task automatic start(input int len, input int tmo);
    bus.start_i = 1'b1;
    bus.len_i   = len[7:0];
    bus.tmo_i   = tmo[7:0];
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bus.psram_io_in_i  = v;
    bus.psram_dqs_in_i = ~bus.psram_dqs_in_i;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gmin, input int gmax);
    foreach (b[i]) begin
      send_byte(b[i]);
      repeat ($urandom_range(gmax, gmin)) tick();
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] b[$]);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && bus.busy_o; i++) tick();
    check(name, bus.busy_o, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // rready driver
  initial begin
    int cyc = 0;
    bus.rready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rr_mode)
        0:       bus.rready_i = 1'b0;
        1:       bus.rready_i = ($urandom_range(1, 0) == 1) || (cyc % 3 == 0);
        default: bus.rready_i = 1'b1;
      endcase
    end
  end

  // Monitor: counts done pulses, checks every popped word against the queue.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.done_o) done_cnt++;
        if (bus.rvalid_o && bus.rready_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious word: got %0h expected none", {bus.rlast_o, bus.rdata_o});
          end else begin
            e = exp_q.pop_front();
            check("rx word", {bus.rlast_o, bus.rdata_o}, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] tail[$];
    int d0, len, tmo;

    bus.start_i = 1'b0;
    bus.len_i = '0;
    bus.tmo_i = '0;
    bus.psram_dqs_in_i = 1'b0;
    bus.psram_io_in_i = '0;
    repeat (3) tick();
    check("reset outputs", {bus.busy_o, bus.done_o, bus.tmo_err_o, bus.ovf_err_o,
                            bus.rvalid_o, bus.rlast_o, bus.rdata_o}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // len=0 is not accepted
    start(0, 0);
    check("len0 ignored", bus.busy_o, 0);

    // 4-byte burst, with pin-to-rvalid latency measured on an empty FIFO
    rr_mode = 0;
    d0 = done_cnt;
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    model_words(bq, 99);
    start(4, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(bq[i]);
      repeat (2) tick();
    end
    send_byte(bq[3]);
    repeat (3) tick();
    check("latency pre", bus.rvalid_o, 0);
    tick();
    check("latency 4clk", bus.rvalid_o, 1);
    check("head rlast", bus.rlast_o, 1);
    wait_idle("burst4 idle");
    check("burst4 done", done_cnt - d0, 1);
    rr_mode = 2;
    drain("burst4 drain");

    // 6-byte burst: full word then zero-padded partial word
    rr_mode = 1;
    d0 = done_cnt;
    bq = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    model_words(bq, 99);
    start(6, 0);
    send_bytes(bq, 1, 3);
    wait_idle("burst6 idle");
    check("burst6 done", done_cnt - d0, 1);
    drain("burst6 drain");

    // Timeout after two edges: flag set 10 cycles after the second edge
    d0 = done_cnt;
    start(8, 10);
    send_byte(8'h5A);
    repeat (3) tick();
    send_byte(8'hC3);
    repeat (12) tick();
    check("tmo not yet", bus.tmo_err_o, 0);
    tick();
    check("tmo flag", bus.tmo_err_o, 1);
    check("tmo idle", bus.busy_o, 0);
    check("tmo no done", done_cnt - d0, 0);
    check("tmo no push", bus.rvalid_o, 0);

    // Overflow: rready held low, 5 words into a 4-deep FIFO
    rr_mode = 0;
    d0 = done_cnt;
    rand_bytes(20, bq);
    model_words(bq, 4);
    start(20, 0);
    check("start clears tmo", bus.tmo_err_o, 0);
    send_bytes(bq, 1, 2);
    wait_idle("ovf idle");
    check("ovf flag", bus.ovf_err_o, 1);
    check("ovf done", done_cnt - d0, 1);
    rr_mode = 2;
    drain("ovf drain");
    bq = {8'h01, 8'h02, 8'h03, 8'h04};
    model_words(bq, 99);
    start(4, 0);
    check("start clears ovf", bus.ovf_err_o, 0);
    send_bytes(bq, 1, 2);
    wait_idle("post-ovf idle");
    drain("post-ovf drain");

    // start_i mid-burst is ignored; DQS in IDLE is ignored
    rr_mode = 1;
    d0 = done_cnt;
    rand_bytes(8, bq);
    model_words(bq, 99);
    start(8, 0);
    tail = bq[3:7];
    bq = bq[0:2];
    send_bytes(bq, 2, 2);
    start(2, 5);
    send_bytes(tail, 1, 3);
    wait_idle("midstart idle");
    check("midstart done", done_cnt - d0, 1);
    drain("midstart drain");
    d0 = done_cnt;
    rand_bytes(6, bq);
    send_bytes(bq, 2, 2);
    repeat (4) tick();
    check("idle dqs no push", bus.rvalid_o, 0);
    check("idle dqs no done", done_cnt - d0, 0);
    rand_bytes(5, bq);
    model_words(bq, 99);
    start(5, 0);
    send_bytes(bq, 1, 3);
    wait_idle("after idle-dqs idle");
    drain("after idle-dqs drain");

    // Reset mid-burst after 3 bytes
    rr_mode = 2;
    rand_bytes(3, bq);
    start(8, 0);
    send_bytes(bq, 2, 2);
    rst_n = 1'b0;
    tick();
    check("midreset outputs", {bus.busy_o, bus.done_o, bus.tmo_err_o, bus.ovf_err_o,
                               bus.rvalid_o, bus.rlast_o, bus.rdata_o}, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    d0 = done_cnt;
    bq = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model_words(bq, 99);
    start(4, 0);
    send_bytes(bq, 1, 2);
    wait_idle("post-reset idle");
    check("post-reset done", done_cnt - d0, 1);
    drain("post-reset drain");

    // Randomised bursts including len 1 and 255
    rr_mode = 1;
    for (int n = 0; n < 24; n++) begin
      len = (n == 0) ? 1 : (n == 1) ? 255 : $urandom_range(40, 1);
      tmo = ($urandom_range(1, 0) == 1) ? 30 : 0;
      d0 = done_cnt;
      rand_bytes(len, bq);
      model_words(bq, 99);
      start(len, tmo);
      send_bytes(bq, 1, 4);
      wait_idle("rand idle");
      check("rand done", done_cnt - d0, 1);
      check("rand no tmo", bus.tmo_err_o, 0);
      check("rand no ovf", bus.ovf_err_o, 0);
    end
    drain("rand drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
